// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR generator.
//   MODE_FIB / MODE_GAL : feedback structure selectors
//   state_t             : run-control states
//   fib_taps / gal_taps : maximal-length tap masks for widths 3..16
//                         (bit i set = bit i participates)
package lfsr_pkg;

   localparam int MODE_FIB = 0;
   localparam int MODE_GAL = 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Fibonacci masks: taps of x^n + ... + 1 placed at bit (tap-1).
   function automatic logic [15:0] fib_taps(input int w);
      case (w)
         3:       return 16'h0006;
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0060;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0829;
         13:      return 16'h100D;
         14:      return 16'h2015;
         15:      return 16'h6000;
         16:      return 16'hD008;
         default: return 16'h0000;
      endcase
   endfunction

   // Galois masks: polynomial coefficients below x^n (x^n implicit).
   function automatic logic [15:0] gal_taps(input int w);
      case (w)
         3:       return 16'h0005;
         4:       return 16'h0009;
         5:       return 16'h0009;
         6:       return 16'h0021;
         7:       return 16'h0041;
         8:       return 16'h0071;
         9:       return 16'h0021;
         10:      return 16'h0081;
         11:      return 16'h0201;
         12:      return 16'h0053;
         13:      return 16'h001B;
         14:      return 16'h002B;
         15:      return 16'h4001;
         16:      return 16'hA011;
         default: return 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational single-step LFSR next-state function.
//   cur : current register state
//   nxt : state after one shift (Fibonacci or Galois per MODE)
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
   parameter int               MODE  = MODE_FIB
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);

   generate
      if (MODE == MODE_GAL) begin : g_gal
         assign nxt = {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? TAPS : '0);
      end else begin : g_fib
         assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
      end
   endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR pattern source with bounded run control.
//   clk, rst          : clock, async active-high reset
//   load, seed_in     : load runtime seed (zero seed -> SEED + lockup)
//   start, run_len    : begin a run of run_len shifts (IDLE only)
//   en, stop          : pause / abort while running
//   lfsr, count       : register state, shifts completed in current/last run
//   busy, done        : running flag, one-cycle completion pulse
//   lockup            : sticky all-zero detection / zero-seed rejection
//
// state | meaning
// IDLE  | register holds; waiting for start or load
// RUN   | shifting on each en cycle until count reaches the latched run length
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01),
   parameter int               MODE  = MODE_FIB,
   parameter int               CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             start,
   input  logic [CNT_W-1:0] run_len,
   input  logic             en,
   input  logic             stop,
   output logic [WIDTH-1:0] lfsr,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             lockup
);

   state_t           state, state_n;
   logic [WIDTH-1:0] lfsr_n, step_nxt;
   logic [CNT_W-1:0] count_n, count_inc, len_q, len_n;
   logic             done_n, lockup_n;

   lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE)
   ) u_step (
      .cur (lfsr),
      .nxt (step_nxt)
   );

   assign count_inc = count + CNT_W'(1);
   assign busy      = (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         lfsr   <= SEED;
         count  <= '0;
         len_q  <= '0;
         done   <= 1'b0;
         lockup <= 1'b0;
      end else begin
         state  <= state_n;
         lfsr   <= lfsr_n;
         count  <= count_n;
         len_q  <= len_n;
         done   <= done_n;
         lockup <= lockup_n;
      end
   end

   always_comb begin
      state_n  = state;
      lfsr_n   = lfsr;
      count_n  = count;
      len_n    = len_q;
      done_n   = 1'b0;
      lockup_n = lockup;

      if (load) begin
         state_n = IDLE;
         count_n = '0;
         if (seed_in == '0) begin
            lfsr_n   = SEED;
            lockup_n = 1'b1;
         end else begin
            lfsr_n   = seed_in;
            lockup_n = 1'b0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  count_n = '0;
                  if (run_len != '0) begin
                     state_n = RUN;
                     len_n   = run_len;
                  end else begin
                     // zero-length run completes immediately
                     done_n = 1'b1;
                  end
               end
            end
            RUN: begin
               if (stop) begin
                  state_n = IDLE;
               end else if (en) begin
                  count_n = count_inc;
                  // all-zero is a dead state; only a bad TAPS mask reaches it
                  if (lfsr == '0) begin
                     lfsr_n   = SEED;
                     lockup_n = 1'b1;
                  end else begin
                     lfsr_n = step_nxt;
                  end
                  if (count_inc == len_q) begin
                     state_n = IDLE;
                     done_n  = 1'b1;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_gen.sv
module tb_lfsr_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [7:0]  seed_in = '0;
   logic        start = 1'b0;
   logic [15:0] run_len = '0;
   logic        en = 1'b0;
   logic        stop = 1'b0;

   logic [2:0]  lf0, lf1;
   logic [7:0]  lf2;
   logic [3:0]  lf3;
   logic [15:0] cnt0, cnt1, cnt2, cnt3;
   logic        busy0, busy1, busy2, busy3;
   logic        done0, done1, done2, done3;
   logic        lock0, lock1, lock2, lock3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // 0: 3-bit Fibonacci, 1: 3-bit Galois, 2: default 8-bit, 3: 4-bit with dead taps
   lfsr_gen #(.WIDTH(3), .TAPS(3'b101), .SEED(3'b100), .MODE(0), .CNT_W(16)) u_fib (
      .clk(clk), .rst(rst), .load(load), .seed_in(seed_in[2:0]), .start(start),
      .run_len(run_len), .en(en), .stop(stop), .lfsr(lf0), .count(cnt0),
      .busy(busy0), .done(done0), .lockup(lock0));

   lfsr_gen #(.WIDTH(3), .TAPS(3'b011), .SEED(3'b100), .MODE(1), .CNT_W(16)) u_gal (
      .clk(clk), .rst(rst), .load(load), .seed_in(seed_in[2:0]), .start(start),
      .run_len(run_len), .en(en), .stop(stop), .lfsr(lf1), .count(cnt1),
      .busy(busy1), .done(done1), .lockup(lock1));

   lfsr_gen u_def (
      .clk(clk), .rst(rst), .load(load), .seed_in(seed_in), .start(start),
      .run_len(run_len), .en(en), .stop(stop), .lfsr(lf2), .count(cnt2),
      .busy(busy2), .done(done2), .lockup(lock2));

   lfsr_gen #(.WIDTH(4), .TAPS(4'b0000), .SEED(4'b0001), .MODE(0), .CNT_W(16)) u_bad (
      .clk(clk), .rst(rst), .load(load), .seed_in(seed_in[3:0]), .start(start),
      .run_len(run_len), .en(en), .stop(stop), .lfsr(lf3), .count(cnt3),
      .busy(busy3), .done(done3), .lockup(lock3));

   // reference model
   int unsigned cw[4]    = '{3, 3, 8, 4};
   int unsigned ctaps[4] = '{5, 3, 'hB8, 0};
   int unsigned cseed[4] = '{4, 4, 1, 1};
   bit          cgal[4]  = '{0, 1, 0, 0};

   int unsigned m_lfsr[4], m_cnt[4], m_len[4];
   bit          m_run[4], m_done[4], m_lock[4];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned ref_step(int unsigned v, int unsigned w,
                                            int unsigned taps, bit gal);
      int unsigned mask = (1 << w) - 1;
      if (gal)
         return ((v << 1) & mask) ^ ((((v >> (w - 1)) & 1) != 0) ? taps : 0);
      else
         return ((v << 1) & mask) | ($countones(v & taps) % 2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_lfsr[i] = cseed[i];
         m_cnt[i]  = 0;
         m_len[i]  = 0;
         m_run[i]  = 0;
         m_done[i] = 0;
         m_lock[i] = 0;
      end
   endtask

   task automatic model_step();
      if (rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 4; i++) begin
         int unsigned mask = (1 << cw[i]) - 1;
         int unsigned sd = seed_in & mask;
         m_done[i] = 0;
         if (load) begin
            m_run[i] = 0;
            m_cnt[i] = 0;
            if (sd == 0) begin
               m_lfsr[i] = cseed[i];
               m_lock[i] = 1;
            end else begin
               m_lfsr[i] = sd;
               m_lock[i] = 0;
            end
         end else if (m_run[i]) begin
            if (stop) begin
               m_run[i] = 0;
            end else if (en) begin
               if (m_lfsr[i] == 0) begin
                  m_lfsr[i] = cseed[i];
                  m_lock[i] = 1;
               end else begin
                  m_lfsr[i] = ref_step(m_lfsr[i], cw[i], ctaps[i], cgal[i]);
               end
               m_cnt[i] = (m_cnt[i] + 1) % 65536;
               if (m_cnt[i] == m_len[i]) begin
                  m_run[i]  = 0;
                  m_done[i] = 1;
               end
            end
         end else if (start) begin
            m_cnt[i] = 0;
            if (run_len != 0) begin
               m_run[i] = 1;
               m_len[i] = run_len;
            end else begin
               m_done[i] = 1;
            end
         end
      end
   endtask

   task automatic get_obs(input int i, output logic [31:0] lf, output logic [31:0] cn,
                          output logic [31:0] bs, output logic [31:0] dn,
                          output logic [31:0] lk);
      case (i)
         0: begin lf = 32'(lf0); cn = 32'(cnt0); bs = 32'(busy0); dn = 32'(done0); lk = 32'(lock0); end
         1: begin lf = 32'(lf1); cn = 32'(cnt1); bs = 32'(busy1); dn = 32'(done1); lk = 32'(lock1); end
         2: begin lf = 32'(lf2); cn = 32'(cnt2); bs = 32'(busy2); dn = 32'(done2); lk = 32'(lock2); end
         default: begin lf = 32'(lf3); cn = 32'(cnt3); bs = 32'(busy3); dn = 32'(done3); lk = 32'(lock3); end
      endcase
   endtask

   task automatic compare_all();
      logic [31:0] lf, cn, bs, dn, lk;
      for (int i = 0; i < 4; i++) begin
         get_obs(i, lf, cn, bs, dn, lk);
         chk($sformatf("u%0d.lfsr", i),   lf, m_lfsr[i]);
         chk($sformatf("u%0d.count", i),  cn, m_cnt[i]);
         chk($sformatf("u%0d.busy", i),   bs, 32'(m_run[i]));
         chk($sformatf("u%0d.done", i),   dn, 32'(m_done[i]));
         chk($sformatf("u%0d.lockup", i), lk, 32'(m_lock[i]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_load(input logic [7:0] s);
      load = 1'b1; seed_in = s;
      tick();
      load = 1'b0;
   endtask

   task automatic do_start(input logic [15:0] n);
      start = 1'b1; run_len = n;
      tick();
      start = 1'b0;
   endtask

   initial begin
      logic [2:0] fib_tab[7];
      logic [2:0] gal_tab[6];
      int nd;
      fib_tab = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b101, 3'b010, 3'b100};
      gal_tab = '{3'b011, 3'b110, 3'b111, 3'b101, 3'b001, 3'b010};
      model_reset();

      // reset state
      tick();
      chk("rst.lfsr8", 32'(lf2), 32'h01);
      chk("rst.busy", 32'(busy0), 0);
      rst = 1'b0;
      en  = 1'b1;

      // Fibonacci order, 7 shifts
      do_start(16'd7);
      chk("fib.busy", 32'(busy0), 1);
      nd = 0;
      for (int k = 0; k < 7; k++) begin
         tick();
         chk($sformatf("fib.seq%0d", k), 32'(lf0), 32'(fib_tab[k]));
         if (done0) nd++;
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         if (done0) nd++;
      end
      chk("fib.done_pulses", nd, 1);
      chk("fib.count", 32'(cnt0), 7);
      chk("fib.busy_end", 32'(busy0), 0);

      // Galois order, 6 shifts
      do_load(8'h04);
      do_start(16'd6);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("gal.seq%0d", k), 32'(lf1), 32'(gal_tab[k]));
      end
      chk("gal.count", 32'(cnt1), 6);
      chk("gal.done", 32'(done1), 1);

      // legacy 5-step run, then hold
      do_load(8'h04);
      do_start(16'd5);
      for (int k = 0; k < 5; k++) tick();
      chk("legacy.count", 32'(cnt0), 5);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("legacy.hold%0d", k), 32'(lf0), 32'h5);
         tick();
      end

      // pause and abort; start/run_len changes while busy are ignored
      do_load(8'h04);
      do_start(16'd7);
      start = 1'b1; run_len = 16'd2;
      tick(); tick();
      start = 1'b0;
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("pause.lfsr", 32'(lf0), 32'h3);
         chk("pause.count", 32'(cnt0), 2);
         chk("pause.busy", 32'(busy0), 1);
      end
      en = 1'b1;
      tick(); tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop.busy", 32'(busy0), 0);
      chk("stop.done", 32'(done0), 0);
      chk("stop.lfsr", 32'(lf0), 32'h6);
      chk("stop.count", 32'(cnt0), 4);
      tick();
      chk("stop.done_after", 32'(done0), 0);

      // zero handling
      do_load(8'h00);
      chk("zero.lfsr", 32'(lf2), 32'h01);
      chk("zero.lockup", 32'(lock2), 1);
      do_start(16'd0);
      chk("len0.done", 32'(done2), 1);
      chk("len0.lfsr", 32'(lf2), 32'h01);
      chk("len0.busy", 32'(busy2), 0);
      tick();
      chk("len0.done_once", 32'(done2), 0);
      do_load(8'h5A);
      chk("reload.lockup", 32'(lock2), 0);
      chk("reload.lfsr", 32'(lf2), 32'h5A);

      // asynchronous reset mid-run
      do_start(16'd7);
      tick(); tick(); tick();
      #2 rst = 1'b1;
      #1;
      chk("arst.lfsr", 32'(lf2), 32'h01);
      chk("arst.lfsr3", 32'(lf0), 32'h4);
      chk("arst.count", 32'(cnt2), 0);
      chk("arst.busy", 32'(busy2), 0);
      chk("arst.done", 32'(done2), 0);
      chk("arst.lockup", 32'(lock3), 0);
      model_reset();
      tick();
      rst = 1'b0;

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         load    = ($urandom % 32) == 0;
         seed_in = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
         start   = ($urandom % 4) == 0;
         run_len = 16'($urandom_range(0, 12));
         en      = ($urandom % 4) != 0;
         stop    = ($urandom % 24) == 0;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
